// File: rtl/ux607_jtag_tap_os.sv
// Oversampled IEEE 1149.1 TAP controller.
// TCK/TMS/TDI/TRST are sampled as data in the system clock domain. TCK edges
// are detected after synchronization, and the 16-state TAP FSM, the IR and
// the IDCODE/BYPASS registers all advance on those detected edges. Any
// instruction other than IDCODE or BYPASS is routed to an external DR port
// as capture/shift/update pulses.
//
// Handshake: dr_capture, dr_shift and dr_update are single-clock strobes with
// no back-pressure. dr_tdi is valid in the cycle dr_shift is high. dr_tdo must
// hold the external DR LSB whenever a TCK fall can occur in Shift-DR.
module ux607_jtag_tap_os #(
   parameter int          IR_W        = 5,
   parameter logic [31:0] IDCODE_VAL  = 32'h1E200A6D,
   parameter int          SYNC_STAGES = 2
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            io_jtag_TCK,
   input  logic            io_jtag_TMS,
   input  logic            io_jtag_TDI,
   input  logic            io_jtag_TRST,
   output logic            io_jtag_TDO,
   output logic            io_jtag_DRV_TDO,
   output logic [3:0]      tap_state,
   output logic [IR_W-1:0] ir,
   output logic            dr_capture,
   output logic            dr_shift,
   output logic            dr_update,
   output logic            dr_tdi,
   input  logic            dr_tdo
);

   // IEEE 1149.1 state encoding; tap_state exposes it directly.
   typedef enum logic [3:0] {
      TAP_EX2_DR   = 4'h0,
      TAP_EX1_DR   = 4'h1,
      TAP_SH_DR    = 4'h2,
      TAP_PAUSE_DR = 4'h3,
      TAP_SEL_IR   = 4'h4,
      TAP_UPD_DR   = 4'h5,
      TAP_CAP_DR   = 4'h6,
      TAP_SEL_DR   = 4'h7,
      TAP_EX2_IR   = 4'h8,
      TAP_EX1_IR   = 4'h9,
      TAP_SH_IR    = 4'hA,
      TAP_PAUSE_IR = 4'hB,
      TAP_RTI      = 4'hC,
      TAP_UPD_IR   = 4'hD,
      TAP_CAP_IR   = 4'hE,
      TAP_TLR      = 4'hF
   } tap_state_e;

   localparam logic [IR_W-1:0] IR_IDCODE  = {{(IR_W-1){1'b0}}, 1'b1};
   localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-1){1'b0}}, 1'b1};

   // Bit positions inside one synchronizer stage.
   localparam int B_TCK  = 0;
   localparam int B_TMS  = 1;
   localparam int B_TDI  = 2;
   localparam int B_TRST = 3;

   // ------------------------------------------------------------------
   // Synchronizers and TCK edge detection
   // ------------------------------------------------------------------
   logic [3:0] sync_q [SYNC_STAGES];

   // All four pin signals share one chain so TMS/TDI stay aligned to TCK.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= 4'b0000;
         end
      end else begin
         sync_q[0] <= {io_jtag_TRST, io_jtag_TDI, io_jtag_TMS, io_jtag_TCK};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   logic tck_s;
   logic tms_s;
   logic tdi_s;
   logic trst_s;
   logic tck_prev;
   logic tck_stable;

   assign tck_s  = sync_q[SYNC_STAGES-1][B_TCK];
   assign tms_s  = sync_q[SYNC_STAGES-1][B_TMS];
   assign tdi_s  = sync_q[SYNC_STAGES-1][B_TDI];
   assign trst_s = sync_q[SYNC_STAGES-1][B_TRST];

   // The stage before the last one lets a single-sample TCK glitch be
   // ignored: an edge only counts when two consecutive samples agree.
   generate
      if (SYNC_STAGES >= 2) begin : g_prev_stage
         assign tck_prev = sync_q[SYNC_STAGES-2][B_TCK];
      end else begin : g_prev_pin
         assign tck_prev = io_jtag_TCK;
      end
   endgenerate

   assign tck_stable = (tck_s == tck_prev);

   logic tck_p_q;
   logic tck_rise_q;
   logic tck_fall_q;
   logic tms_q;
   logic tdi_q;

   // Filtered TCK level plus registered one-cycle edge strobes and aligned TMS/TDI.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         tck_p_q    <= 1'b0;
         tck_rise_q <= 1'b0;
         tck_fall_q <= 1'b0;
         tms_q      <= 1'b0;
         tdi_q      <= 1'b0;
      end else begin
         if (tck_stable) begin
            tck_p_q <= tck_s;
         end
         tck_rise_q <= tck_stable &  tck_s & ~tck_p_q;
         tck_fall_q <= tck_stable & ~tck_s &  tck_p_q;
         tms_q      <= tms_s;
         tdi_q      <= tdi_s;
      end
   end

   // TAP logic reset: system reset or synchronized TRST, ahead of any edge.
   logic tap_rst;
   assign tap_rst = !reset_n || trst_s;

   // ------------------------------------------------------------------
   // TAP state machine
   // ------------------------------------------------------------------
   tap_state_e state_q;
   tap_state_e state_d;

   // State register.
   always_ff @(posedge clock) begin
      if (tap_rst) begin
         state_q <= TAP_TLR;
      end else begin
         state_q <= state_d;
      end
   end

   // IEEE 1149.1 transitions on TMS, taken only on a detected TCK rise.
   always_comb begin
      state_d = state_q;
      if (tck_rise_q) begin
         case (state_q)
            TAP_TLR:      state_d = tms_q ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      state_d = tms_q ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   state_d = tms_q ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   state_d = tms_q ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:    state_d = tms_q ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR:   state_d = tms_q ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_d = tms_q ? TAP_EX2_DR : TAP_PAUSE_DR;
            TAP_EX2_DR:   state_d = tms_q ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR:   state_d = tms_q ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR:   state_d = tms_q ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   state_d = tms_q ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:    state_d = tms_q ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR:   state_d = tms_q ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_d = tms_q ? TAP_EX2_IR : TAP_PAUSE_IR;
            TAP_EX2_IR:   state_d = tms_q ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR:   state_d = tms_q ? TAP_SEL_DR : TAP_RTI;
            default:      state_d = TAP_TLR;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Instruction register and decode
   // ------------------------------------------------------------------
   logic [IR_W-1:0] ir_sr_q;
   logic [IR_W-1:0] ir_q;
   logic            is_idcode;
   logic            is_bypass;
   logic            is_ext;

   assign is_idcode = (ir_q == IR_IDCODE);
   assign is_bypass = (ir_q == {IR_W{1'b1}}) || (ir_q == {IR_W{1'b0}});
   assign is_ext    = !is_idcode && !is_bypass;

   // IR shift register moves on rises; the live IR loads on the Update-IR fall.
   always_ff @(posedge clock) begin
      if (tap_rst) begin
         ir_sr_q <= '0;
         ir_q    <= IR_IDCODE;
      end else begin
         if (tck_rise_q && state_q == TAP_CAP_IR) begin
            ir_sr_q <= IR_CAPTURE;
         end else if (tck_rise_q && state_q == TAP_SH_IR) begin
            ir_sr_q <= {tdi_q, ir_sr_q[IR_W-1:1]};
         end
         if (state_q == TAP_TLR) begin
            ir_q <= IR_IDCODE;
         end else if (tck_fall_q && state_q == TAP_UPD_IR) begin
            ir_q <= ir_sr_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // Internal data registers
   // ------------------------------------------------------------------
   logic [31:0] id_sr_q;
   logic        byp_q;

   // IDCODE and BYPASS capture/shift on the rise that leaves the state.
   always_ff @(posedge clock) begin
      if (tap_rst) begin
         id_sr_q <= 32'h0;
         byp_q   <= 1'b0;
      end else if (tck_rise_q) begin
         if (state_q == TAP_CAP_DR) begin
            id_sr_q <= IDCODE_VAL;
            byp_q   <= 1'b0;
         end else if (state_q == TAP_SH_DR) begin
            if (is_idcode) begin
               id_sr_q <= {tdi_q, id_sr_q[31:1]};
            end else if (is_bypass) begin
               byp_q <= tdi_q;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // External DR strobes
   // ------------------------------------------------------------------
   logic dr_capture_q;
   logic dr_shift_q;
   logic dr_update_q;
   logic dr_tdi_q;

   // One-clock strobes for external instructions, at most one per TCK edge.
   always_ff @(posedge clock) begin
      if (tap_rst) begin
         dr_capture_q <= 1'b0;
         dr_shift_q   <= 1'b0;
         dr_update_q  <= 1'b0;
         dr_tdi_q     <= 1'b0;
      end else begin
         dr_capture_q <= tck_rise_q && is_ext && (state_q == TAP_CAP_DR);
         dr_shift_q   <= tck_rise_q && is_ext && (state_q == TAP_SH_DR);
         dr_update_q  <= tck_fall_q && is_ext && (state_q == TAP_UPD_DR);
         if (tck_rise_q && is_ext && state_q == TAP_SH_DR) begin
            dr_tdi_q <= tdi_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // TDO path
   // ------------------------------------------------------------------
   logic dr_lsb;
   logic tdo_q;
   logic drv_q;

   // LSB of whichever data register the current instruction selects.
   always_comb begin
      dr_lsb = dr_tdo;
      if (is_idcode) begin
         dr_lsb = id_sr_q[0];
      end else if (is_bypass) begin
         dr_lsb = byp_q;
      end
   end

   // TDO launches on TCK fall in the shift states and holds elsewhere.
   always_ff @(posedge clock) begin
      if (tap_rst) begin
         tdo_q <= 1'b0;
         drv_q <= 1'b0;
      end else if (tck_fall_q) begin
         if (state_q == TAP_SH_IR) begin
            tdo_q <= ir_sr_q[0];
            drv_q <= 1'b1;
         end else if (state_q == TAP_SH_DR) begin
            tdo_q <= dr_lsb;
            drv_q <= 1'b1;
         end else begin
            drv_q <= 1'b0;
         end
      end
   end

   assign io_jtag_TDO     = tdo_q;
   assign io_jtag_DRV_TDO = drv_q;
   assign tap_state       = state_q;
   assign ir              = ir_q;
   assign dr_capture      = dr_capture_q;
   assign dr_shift        = dr_shift_q;
   assign dr_update       = dr_update_q;
   assign dr_tdi          = dr_tdi_q;

endmodule
